// File: rtl/core_ibex_dii_sequencer_if.sv
// Handshake bundle between the DII driver/core and the DII sequencer.
// The slave modport is the sequencer side; the master modport is the driver/core side.
interface core_ibex_dii_sequencer_if;
    logic        push_valid_i;
    logic [31:0] push_instr_i;
    logic        push_ready_o;
    logic        instr_valid_o;
    logic [31:0] instr_rdata_dii_o;
    logic        instr_ack_i;
    logic        rvfi_valid_i;

    modport slave (
        input  push_valid_i, push_instr_i, instr_ack_i, rvfi_valid_i,
        output push_ready_o, instr_valid_o, instr_rdata_dii_o
    );

    modport master (
        output push_valid_i, push_instr_i, instr_ack_i, rvfi_valid_i,
        input  push_ready_o, instr_valid_o, instr_rdata_dii_o
    );
endinterface

// File: rtl/core_ibex_dii_sequencer.sv
// DII sequencer: buffers driver-pushed instruction words and injects them one at a time,
// throttled by the number of injected-but-unretired instructions.
module core_ibex_dii_sequencer #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned MAX_INFLIGHT = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable_i,
    input  logic                         flush_i,
    core_ibex_dii_sequencer_if.slave     dii,
    output logic [7:0]                   inflight_o,
    output logic [$clog2(DEPTH):0]       fifo_count_o,
    output logic [31:0]                  injected_cnt_o,
    output logic [31:0]                  retired_cnt_o,
    output logic                         idle_o,
    output logic                         retire_err_o
);

    localparam int unsigned  PtrW   = $clog2(DEPTH);
    localparam logic [PtrW:0] DepthC = (PtrW+1)'(DEPTH);
    localparam logic [7:0]   MaxC   = 8'(MAX_INFLIGHT);
    localparam logic [31:0]  Nop    = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e          state_q, state_d;
    logic [31:0]     mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [PtrW:0]   count_q, count_d;
    logic [7:0]      inflight_q, inflight_d;
    logic [31:0]     injected_q, retired_q;
    logic            err_q;

    logic head_valid, push_fire, pop_fire, retire_dec;

    // Presentation depends only on registered state so the core sees a clean, glitch-free word.
    assign head_valid = (state_q == RUN) && (count_q != '0) && (inflight_q < MaxC);
    assign push_fire  = dii.push_valid_i && dii.push_ready_o;
    assign pop_fire   = dii.instr_ack_i && head_valid && !flush_i;
    assign retire_dec = dii.rvfi_valid_i && !pop_fire && (inflight_q != '0);

    assign dii.push_ready_o      = (count_q < DepthC) && !flush_i;
    assign dii.instr_valid_o     = head_valid;
    assign dii.instr_rdata_dii_o = head_valid ? mem_q[rd_ptr_q] : Nop;

    assign inflight_o     = inflight_q;
    assign fifo_count_o   = count_q;
    assign injected_cnt_o = injected_q;
    assign retired_cnt_o  = retired_q;
    assign retire_err_o   = err_q;
    assign idle_o         = (state_q == IDLE) && (count_q == '0) && (inflight_q == '0);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        if (flush_i) begin
            state_d    = enable_i ? RUN : IDLE;
            count_d    = '0;
            inflight_d = '0;
        end else begin
            unique case (state_q)
                IDLE:    if (enable_i) state_d = RUN;
                RUN:     if (!enable_i) state_d = (inflight_q == '0) ? IDLE : DRAIN;
                DRAIN: begin
                    if (enable_i)                 state_d = RUN;
                    else if (inflight_q == '0)    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            if (push_fire && !pop_fire)      count_d = count_q + 1'b1;
            else if (pop_fire && !push_fire) count_d = count_q - 1'b1;
            // A simultaneous ack and retire leaves the in-flight count where it was.
            if (pop_fire && !dii.rvfi_valid_i) inflight_d = inflight_q + 1'b1;
            else if (retire_dec)               inflight_d = inflight_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            injected_q <= '0;
            retired_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            if (flush_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop_fire)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (pop_fire)          injected_q <= injected_q + 1'b1;
            if (dii.rvfi_valid_i)  retired_q  <= retired_q + 1'b1;
            if (dii.rvfi_valid_i && (inflight_q == '0)) err_q <= 1'b1;
        end
    end

    // Storage needs no reset; only entries between the pointers are ever presented.
    always_ff @(posedge clk) begin
        if (push_fire) mem_q[wr_ptr_q] <= dii.push_instr_i;
    end

endmodule

// File: tb/tb_core_ibex_dii_sequencer.sv
// Self-checking bench for the DII sequencer: scoreboard of injected words plus
// directed checks of counts, throttling, flush, drain and asynchronous reset.
module tb_core_ibex_dii_sequencer;

    localparam logic [31:0] NopWord = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n;
    logic enable, flush;
    logic enable2, flush2;

    logic [7:0]  inflight, inflight2;
    logic [2:0]  fifoCount, fifoCount2;
    logic [31:0] injectedCnt, retiredCnt, injectedCnt2, retiredCnt2;
    logic        idle, retireErr, idle2, retireErr2;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] expQ [$];

    core_ibex_dii_sequencer_if dii1 ();
    core_ibex_dii_sequencer_if dii2 ();

    always #5 clk = ~clk;

    core_ibex_dii_sequencer #(.DEPTH(4), .MAX_INFLIGHT(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable_i       (enable),
        .flush_i        (flush),
        .dii            (dii1),
        .inflight_o     (inflight),
        .fifo_count_o   (fifoCount),
        .injected_cnt_o (injectedCnt),
        .retired_cnt_o  (retiredCnt),
        .idle_o         (idle),
        .retire_err_o   (retireErr)
    );

    core_ibex_dii_sequencer #(.DEPTH(4), .MAX_INFLIGHT(2)) dutThrottle (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable_i       (enable2),
        .flush_i        (flush2),
        .dii            (dii2),
        .inflight_o     (inflight2),
        .fifo_count_o   (fifoCount2),
        .injected_cnt_o (injectedCnt2),
        .retired_cnt_o  (retiredCnt2),
        .idle_o         (idle2),
        .retire_err_o   (retireErr2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives the main instance for one clock; expected accepted pushes enter the scoreboard.
    task automatic applyStimulus(input logic pv, input logic [31:0] word, input logic ack,
                                 input logic rv, input logic expectAccept);
        dii1.push_valid_i = pv;
        dii1.push_instr_i = word;
        dii1.instr_ack_i  = ack;
        dii1.rvfi_valid_i = rv;
        if (pv && expectAccept) expQ.push_back(word);
        step();
    endtask

    task automatic applyStimulus2(input logic pv, input logic [31:0] word, input logic ack, input logic rv);
        dii2.push_valid_i = pv;
        dii2.push_instr_i = word;
        dii2.instr_ack_i  = ack;
        dii2.rvfi_valid_i = rv;
        step();
    endtask

    // Every accepted injection of the main instance must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && !flush && dii1.instr_ack_i && dii1.instr_valid_o) begin
            if (expQ.size() == 0) checkOutput("sbUnderflow", 32'(expQ.size()), 32'd1);
            else                  checkOutput("sbWord", dii1.instr_rdata_dii_o, expQ.pop_front());
        end
    end

    initial begin
        rst_n = 1'b0;
        enable = 1'b0; flush = 1'b0; enable2 = 1'b0; flush2 = 1'b0;
        dii1.push_valid_i = 1'b0; dii1.push_instr_i = '0; dii1.instr_ack_i = 1'b0; dii1.rvfi_valid_i = 1'b0;
        dii2.push_valid_i = 1'b0; dii2.push_instr_i = '0; dii2.instr_ack_i = 1'b0; dii2.rvfi_valid_i = 1'b0;
        #12;
        checkOutput("rstReady",    32'(dii1.push_ready_o), 32'd1);
        checkOutput("rstValid",    32'(dii1.instr_valid_o), 32'd0);
        checkOutput("rstRdata",    dii1.instr_rdata_dii_o, NopWord);
        checkOutput("rstInflight", 32'(inflight), 32'd0);
        checkOutput("rstCount",    32'(fifoCount), 32'd0);
        checkOutput("rstIdle",     32'(idle), 32'd1);
        checkOutput("rstErr",      32'(retireErr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Throttle with MAX_INFLIGHT=2 on the second instance.
        enable2 = 1'b1;
        step();
        for (int i = 0; i < 4; i++) applyStimulus2(1'b1, 32'h0000_1000 + 32'(i), 1'b0, 1'b0);
        checkOutput("thrFull",  32'(fifoCount2), 32'd4);
        checkOutput("thrHead0", dii2.instr_rdata_dii_o, 32'h0000_1000);
        applyStimulus2(1'b0, '0, 1'b1, 1'b0);
        checkOutput("thrHead1", dii2.instr_rdata_dii_o, 32'h0000_1001);
        for (int i = 0; i < 3; i++) applyStimulus2(1'b0, '0, 1'b1, 1'b0);
        checkOutput("thrInjected", injectedCnt2, 32'd2);
        checkOutput("thrInflight", 32'(inflight2), 32'd2);
        checkOutput("thrValidLow", 32'(dii2.instr_valid_o), 32'd0);
        checkOutput("thrNop",      dii2.instr_rdata_dii_o, NopWord);
        checkOutput("thrCount",    32'(fifoCount2), 32'd2);
        applyStimulus2(1'b0, '0, 1'b0, 1'b1);
        applyStimulus2(1'b0, '0, 1'b0, 1'b0);
        checkOutput("thrRelease",  32'(dii2.instr_valid_o), 32'd1);
        checkOutput("thrHead2",    dii2.instr_rdata_dii_o, 32'h0000_1002);

        // In-order injection with an ack every cycle.
        enable = 1'b1;
        step();
        applyStimulus(1'b1, 32'h0000_0093, 1'b1, 1'b0, 1'b1);
        checkOutput("latValid", 32'(dii1.instr_valid_o), 32'd1);
        applyStimulus(1'b1, 32'h0010_0113, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h0020_0193, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        dii1.instr_ack_i = 1'b0;
        checkOutput("seqInjected", injectedCnt, 32'd3);
        checkOutput("seqInflight", 32'(inflight), 32'd3);
        checkOutput("seqNop",      dii1.instr_rdata_dii_o, NopWord);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("seqRetInflight", 32'(inflight), 32'd0);
        checkOutput("seqRetired",     retiredCnt, 32'd3);

        // Fill the FIFO, then a push alongside a pop on a full FIFO must be rejected.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h0000_2000 + 32'(i), 1'b0, 1'b0, 1'b1);
        checkOutput("fullCount", 32'(fifoCount), 32'd4);
        checkOutput("fullReady", 32'(dii1.push_ready_o), 32'd0);
        applyStimulus(1'b1, 32'h0000_2FFF, 1'b1, 1'b0, 1'b0);
        checkOutput("noBypassCount", 32'(fifoCount), 32'd3);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0000_2004, 1'b0, 1'b0, 1'b1);
        checkOutput("preFlushCount",    32'(fifoCount), 32'd3);
        checkOutput("preFlushInflight", 32'(inflight), 32'd2);

        // Flush with a simultaneous push and retire.
        flush = 1'b1;
        dii1.push_valid_i = 1'b1;
        #1;
        checkOutput("flushReady", 32'(dii1.push_ready_o), 32'd0);
        applyStimulus(1'b1, 32'h0000_3000, 1'b0, 1'b1, 1'b0);
        flush = 1'b0;
        expQ.delete();
        dii1.push_valid_i = 1'b0; dii1.rvfi_valid_i = 1'b0;
        #1;
        checkOutput("flushCount",    32'(fifoCount), 32'd0);
        checkOutput("flushInflight", 32'(inflight), 32'd0);
        checkOutput("flushRetired",  retiredCnt, 32'd4);
        checkOutput("flushInjected", injectedCnt, 32'd5);
        checkOutput("flushErr",      32'(retireErr), 32'd0);

        // Drain: drop enable with two instructions in flight.
        applyStimulus(1'b1, 32'h0000_4000, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h0000_4001, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        dii1.instr_ack_i = 1'b0;
        checkOutput("sbDrained", 32'(expQ.size()), 32'd0);
        enable = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("drainInflight", 32'(inflight), 32'd2);
        checkOutput("drainValid",    32'(dii1.instr_valid_o), 32'd0);
        checkOutput("drainIdle",     32'(idle), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("drainStillBusy", 32'(idle), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("drainIdleReached", 32'(idle), 32'd1);
        checkOutput("drainErrClear",    32'(retireErr), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("errSticky",  32'(retireErr), 32'd1);
        checkOutput("errRetired", retiredCnt, 32'd7);
        checkOutput("errInflight", 32'(inflight), 32'd0);

        // Asynchronous reset mid-run with the FIFO partly full.
        enable = 1'b1;
        applyStimulus(1'b1, 32'h0000_5000, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h0000_5001, 1'b0, 1'b0, 1'b1);
        dii1.push_valid_i = 1'b0;
        #1;
        checkOutput("midCount", 32'(fifoCount), 32'd2);
        checkOutput("midValid", 32'(dii1.instr_valid_o), 32'd1);
        #1;
        rst_n = 1'b0;
        expQ.delete();
        #1;
        checkOutput("arstCount",    32'(fifoCount), 32'd0);
        checkOutput("arstValid",    32'(dii1.instr_valid_o), 32'd0);
        checkOutput("arstRdata",    dii1.instr_rdata_dii_o, NopWord);
        checkOutput("arstInjected", injectedCnt, 32'd0);
        checkOutput("arstRetired",  retiredCnt, 32'd0);
        checkOutput("arstErr",      32'(retireErr), 32'd0);
        checkOutput("arstIdle",     32'(idle), 32'd1);
        checkOutput("arstReady",    32'(dii1.push_ready_o), 32'd1);
        checkOutput("arstThrCount", 32'(fifoCount2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/core_ibex_dii_sequencer.md
# core_ibex_dii_sequencer

Direct-instruction-injection (DII) sequencer for the core_ibex UVM environment. Buffers instruction words pushed by the DII driver and presents them one at a time to the core's DII fetch port. Throttles injection so that no more than MAX_INFLIGHT instructions are injected but not yet retired. Supports enable/drain control and a flush, and keeps free-running injected and retired counters for scoreboard checks.

## Interface
- DEPTH, 4: instruction FIFO entries; power of two, ≥2.
- MAX_INFLIGHT, 8: maximum injected-but-unretired instructions; 1..255.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable_i  in  1  level; 1 = inject, 0 = stop injecting and drain.
- flush_i  in  1  single-cycle pulse; discard queued and in-flight bookkeeping.
- push_valid_i  in  1  driver offers push_instr_i.
- push_instr_i  in  32  instruction word to enqueue.
- push_ready_o  out  1  FIFO can accept this cycle.
- instr_valid_o  out  1  instr_rdata_dii_o holds a real queued instruction.
- instr_rdata_dii_o  out  32  FIFO head word; 0x0000_0013 (NOP) when instr_valid_o=0.
- instr_ack_i  in  1  core consumed the presented word this cycle.
- rvfi_valid_i  in  1  one instruction retired this cycle.
- inflight_o  out  8  injected-but-unretired count.
- fifo_count_o  out  $clog2(DEPTH)+1  queued entries.
- injected_cnt_o  out  32  total accepted acks of valid words.
- retired_cnt_o  out  32  total rvfi_valid_i pulses.
- idle_o  out  1  state IDLE, FIFO empty, inflight_o=0.
- retire_err_o  out  1  sticky: retire seen with inflight_o=0.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: instr_valid_o=0; enable_i=1 → RUN next cycle.
- RUN: instr_valid_o = (fifo_count_o>0) && (inflight_o<MAX_INFLIGHT) && enable_i is not checked combinationally (uses registered state only); enable_i=0 → DRAIN, or IDLE if inflight_o=0.
- DRAIN: instr_valid_o=0; pushes still accepted; inflight_o=0 → IDLE; enable_i=1 → RUN (has priority over IDLE).
- Push: accepted when push_valid_i && push_ready_o; push_ready_o = (fifo_count_o<DEPTH) && !flush_i. No bypass: full FIFO with a simultaneous pop still rejects the push.
- Ack: counts only when instr_ack_i && instr_valid_o: pop head, inflight+1, injected_cnt+1. Ack with instr_valid_o=0 ignored.
- Retire: rvfi_valid_i with inflight_o>0 → inflight−1; with inflight_o=0 → inflight stays 0, retire_err_o set. retired_cnt+1 on every pulse.
- Ack and retire in the same cycle: inflight unchanged.
- Flush (highest priority): FIFO emptied, inflight cleared, same-cycle push/ack/retire ignored for FIFO and inflight; next state RUN if enable_i=1 else IDLE. Flush does not clear injected_cnt_o, retired_cnt_o or retire_err_o. retired_cnt_o still counts a same-cycle retire.
- Counters wrap at 2^32 with no flag.

## Timing
- Reset values: push_ready_o=1, instr_valid_o=0, instr_rdata_dii_o=0x0000_0013, inflight_o=0, fifo_count_o=0, counters=0, idle_o=1, retire_err_o=0, state IDLE.
- Push-to-present latency: 1 cycle. A word pushed at edge N is presented after N if the FIFO was empty and throttle allows.
- Back-to-back: one pop per cycle. The next head is presented the cycle after an ack.
- instr_valid_o, instr_rdata_dii_o, idle_o, and all counts are derived from registers only. push_ready_o has one combinational input, flush_i.
- Throttle release: a retire at edge N that brings inflight below MAX re-asserts instr_valid_o after N.
- enable_i to state change: 1 cycle.

## Test plan
- Push 0x0000_0093, 0x0010_0113, 0x0020_0193 while enable=1, ack every cycle → words are presented in order, injected_cnt_o=3, inflight_o=3; three retires → inflight_o=0 and retired_cnt_o=3.
- MAX_INFLIGHT=2, 4 words queued, no retires → exactly 2 acks counted, then instr_valid_o=0 with NOP presented; one retire → instr_valid_o=1 the next cycle.
- Fill the FIFO to DEPTH=4 → push_ready_o=0; ack and push in the same cycle → push rejected, fifo_count_o=3.
- Flush with 3 queued and inflight_o=2, with push and retire in the same cycle → fifo_count_o=0, inflight_o=0, retired_cnt_o+1, counters otherwise held.
- Drop enable_i with inflight_o=2 → DRAIN with instr_valid_o=0; after 2 retires → IDLE and idle_o=1 once the FIFO is empty. Any further retire → retire_err_o=1 and stays set.
- Assert rst_n=0 mid-run with the FIFO partly full → all outputs return to their reset values asynchronously.
